// File: rtl/divider_restoring_32by16.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor.
// Produces one quotient bit per clock with a start/done handshake. The
// divide-by-zero and quotient-overflow cases are decided up front and
// finish right away instead of running the N-step loop.
module divider_restoring_32by16 #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    rem_q,   rem_d;    // partial remainder R
  logic [N-1:0]    shq_q,   shq_d;    // dividend low half shifting out, quotient bits shifting in
  logic [N-1:0]    dvs_q,   dvs_d;    // latched divisor
  logic [CW-1:0]   cnt_q,   cnt_d;    // iterations still to run
  logic [N-1:0]    quot_q,  quot_d;
  logic [N-1:0]    remo_q,  remo_d;
  logic            dbz_q,   dbz_d;
  logic            ovf_q,   ovf_d;

  // One restoring step. The trial value is N+1 bits wide: the bit shifted
  // out of R must take part in the compare, otherwise divisors with the MSB
  // set would produce wrong quotient bits.
  logic [N:0]      trial;
  logic [N:0]      dvs_ext;
  logic            ge;
  logic [N-1:0]    rem_next;
  logic [N-1:0]    shq_next;

  // Combinational datapath for a single restoring iteration
  always_comb begin
    trial    = {rem_q, shq_q[N-1]};
    dvs_ext  = {1'b0, dvs_q};
    ge       = (trial >= dvs_ext);
    rem_next = ge ? N'(trial - dvs_ext) : trial[N-1:0];
    shq_next = {shq_q[N-2:0], ge};
  end

  // Next-state and result logic for the IDLE/RUN/FIN controller
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    shq_d   = shq_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            // Division by zero: saturate quotient, pass low half through.
            quot_d  = '1;
            remo_d  = dividend[N-1:0];
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_FIN;
          end else if (dividend[2*N-1:N] >= divisor) begin
            // Quotient would need more than N bits.
            quot_d  = '1;
            remo_d  = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            rem_d   = dividend[2*N-1:N];
            shq_d   = dividend[N-1:0];
            cnt_d   = CW'(N);
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d = rem_next;
        shq_d = shq_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last iteration: publish the result together with done.
          quot_d  = shq_next;
          remo_d  = rem_next;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      shq_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_FIN);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_restoring_32by16.sv
// Self-checking bench for divider_restoring_32by16: directed cases from the
// test plan plus a randomized sweep checked against plain / and % arithmetic.
module tb_divider_restoring_32by16;

  localparam int N = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int n_cmp = 0;
  int n_mis = 0;

  divider_restoring_32by16 #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain integer division with the error rules.
  task automatic ref_div(input logic [31:0] dvd, input logic [15:0] dvs,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov, output int lat, output int bcnt);
    logic [31:0] qq;
    if (dvs == 16'd0) begin
      q = 16'hFFFF; r = dvd[15:0]; dz = 1'b1; ov = 1'b0; lat = 1; bcnt = 0;
    end else begin
      qq = dvd / {16'd0, dvs};
      if (qq > 32'h0000_FFFF) begin
        q = 16'hFFFF; r = 16'd0; dz = 1'b0; ov = 1'b1; lat = 1; bcnt = 0;
      end else begin
        q = qq[15:0];
        qq = dvd % {16'd0, dvs};
        r = qq[15:0];
        dz = 1'b0; ov = 1'b0;
        // done is sampled high at the edge after the N-th iteration edge
        lat = N + 1; bcnt = N;
      end
    end
  endtask

  // Called while sitting just before a negedge-aligned drive point.
  task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs);
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done, sampling on negedges. lat counts sampling
  // points after the start edge, so 1 means "seen at the next edge".
  task automatic wait_done(input bit poke_fin, output int lat, output int bcnt,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic dz, output logic ov);
    bit seen = 0;
    lat = 0; bcnt = 0; q = '0; r = '0; dz = 0; ov = 0;
    for (int i = 1; i <= 64 && !seen; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        seen = 1; lat = i;
        q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
      end
    end
    check_eq("done_seen", seen, 1);
    if (poke_fin) begin
      start = 1'b1; dividend = 32'd9; divisor = 16'd3;
    end
    @(negedge clk);
    start = 1'b0;
    check_eq("done_width", done, 0);
    check_eq("idle_after_fin", busy, 0);
  endtask

  task automatic run_case(input string tag, input logic [31:0] dvd, input logic [15:0] dvs);
    logic [15:0] eq, er, gq, gr;
    logic edz, eov, gdz, gov;
    int elat, ebc, glat, gbc;
    ref_div(dvd, dvs, eq, er, edz, eov, elat, ebc);
    start_op(dvd, dvs);
    wait_done(1'b0, glat, gbc, gq, gr, gdz, gov);
    check_eq({tag, "_q"}, gq, eq);
    check_eq({tag, "_r"}, gr, er);
    check_eq({tag, "_dz"}, gdz, edz);
    check_eq({tag, "_ov"}, gov, eov);
    check_eq({tag, "_lat"}, glat, elat);
    check_eq({tag, "_busy"}, gbc, ebc);
    if (!edz && !eov) begin
      check_eq({tag, "_inv"}, {32'd0, gq} * {48'd0, dvs} + {48'd0, gr}, {32'd0, dvd});
      check_eq({tag, "_rlt"}, (gr < dvs), 1);
    end
  endtask

  initial begin
    int lat, bc, cnt;
    logic [15:0] q, r, dv;
    logic dz, ov;
    logic [31:0] dd;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_q", quotient, 0);
    check_eq("rst_r", remainder, 0);
    check_eq("rst_dz", div_by_zero, 0);
    check_eq("rst_ov", overflow, 0);

    // Directed cases
    run_case("d15_3", 32'd15, 16'd3);
    run_case("d4047_44", 32'd4047, 16'd44);
    run_case("d4004_91", 32'd4004, 16'd91);
    // 0xFFFF * 0xFBFB = 0xFBFA0405: needs the carry out of R in the compare
    run_case("carry", 32'hFBFA_0405, 16'hFBFB);
    run_case("dbz", 32'h1234_5678, 16'd0);
    run_case("ovf", 32'h0003_0000, 16'd3);
    run_case("ovf_eq", 32'hFFFF_FFFF, 16'hFFFF);
    run_case("max_ok", 32'hFFFE_FFFF, 16'hFFFF);

    // start during RUN and during FIN is ignored
    start_op(32'd100, 16'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1, lat, bc, q, r, dz, ov);
    check_eq("ign_q", q, 16'd14);
    check_eq("ign_r", r, 16'd2);
    check_eq("ign_hold_q", quotient, 16'd14);
    @(negedge clk);
    check_eq("ign_fin_busy", busy, 0);

    // Reset in the middle of RUN aborts without a done pulse
    start_op(32'h0001_2345, 16'h0100);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_q", quotient, 0);
    check_eq("abort_r", remainder, 0);
    check_eq("abort_flags", {div_by_zero, overflow}, 0);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check_eq("abort_no_done", cnt, 0);
    run_case("after_abort", 32'd9, 16'd3);

    // Random sweep of legal operands, issued back to back
    for (int i = 0; i < 1000; i++) begin
      dv = 16'($urandom_range(1, 16'hFFFF));
      dd[31:16] = 16'($urandom % {16'd0, dv});
      dd[15:0]  = 16'($urandom);
      run_case("rnd", dd, dv);
    end

    // A few unconstrained operands, including error cases
    for (int i = 0; i < 40; i++) begin
      dv = (i % 8 == 0) ? 16'd0 : 16'($urandom_range(0, 255));
      dd = $urandom;
      run_case("rnd_any", dd, dv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
